// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding, default taps/seed, feedback function.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W        = 32;
  localparam logic [7:0]  LFSR_DEFAULT_TAPS = 8'hB8;
  localparam logic [7:0]  LFSR_SEED         = 8'h01;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // XOR of the tapped state bits; narrower LFSRs are zero-extended by the caller.
  function automatic logic lfsr_fb(input logic [LFSR_MAX_W-1:0] state,
                                   input logic [LFSR_MAX_W-1:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR step: predicted feedback bit and shifted next state.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] taps_i,
  input  logic             ext_bit_i,
  input  logic             ext_sel_i,
  output logic             pred_c_o,
  output logic [WIDTH-1:0] next_c_o
);

  // Shift in either the external bit or the locally predicted feedback bit.
  always_comb begin
    pred_c_o = lfsr_fb(LFSR_MAX_W'(state_i), LFSR_MAX_W'(taps_i));
    next_c_o = {state_i[WIDTH-2:0], (ext_sel_i ? ext_bit_i : pred_c_o)};
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci LFSR stream, locks, counts bit errors.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] TAPS          = WIDTH'(LFSR_DEFAULT_TAPS),
  parameter int unsigned      LOCK_COUNT    = 16,
  parameter int unsigned      UNLOCK_ERRS   = 4,
  parameter int unsigned      ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     data_i,
  input  logic                     data_valid_i,
  input  logic                     clr_err_i,
  output logic                     locked_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o,
  output logic [WIDTH-1:0]         lfsr_o
);

  localparam int unsigned FILL_W   = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned CONSEC_W = $clog2(UNLOCK_ERRS + 1);

  chk_state_e               state_q,  state_d;
  logic [WIDTH-1:0]         lfsr_q,   lfsr_d;
  logic [FILL_W-1:0]        fill_q,   fill_d;
  logic [MATCH_W-1:0]       match_q,  match_d;
  logic [CONSEC_W-1:0]      consec_q, consec_d;
  logic                     locked_q, locked_d;
  logic                     err_q,    err_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q,    cnt_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_base;
  logic                     pred;
  logic [WIDTH-1:0]         lfsr_next;

  // Received bits feed the register until lock; once locked it free-runs on its own prediction.
  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .state_i   (lfsr_q),
    .taps_i    (TAPS),
    .ext_bit_i (data_i),
    .ext_sel_i (state_q != LOCKED),
    .pred_c_o  (pred),
    .next_c_o  (lfsr_next)
  );

  // Next-state: fill, verify and locked-mode error accounting on valid bits only.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    fill_d   = fill_q;
    match_d  = match_q;
    consec_d = consec_q;
    err_d    = 1'b0;
    cnt_base = clr_err_i ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (data_valid_i) begin
      lfsr_d = lfsr_next;
      case (state_q)
        SEARCH: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          // An all-zero register is the LFSR lock-up state and never counts as a match.
          if ((data_i == pred) && (lfsr_q != '0)) begin
            match_d = match_q + MATCH_W'(1);
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
              state_d  = LOCKED;
              consec_d = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (data_i != pred) begin
            err_d    = 1'b1;
            consec_d = consec_q + CONSEC_W'(1);
            if (cnt_base != '1) begin
              cnt_d = cnt_base + ERR_CNT_WIDTH'(1);
            end
            if (consec_q == CONSEC_W'(UNLOCK_ERRS - 1)) begin
              state_d = SEARCH;
              fill_d  = '0;
            end
          end else begin
            consec_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= SEARCH;
      lfsr_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      consec_q <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      consec_q <= consec_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign err_count_o = cnt_q;
  assign lfsr_o      = lfsr_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Randomised bench for lfsr_prbs_checker against a bit-sequence reference model.
module tb_lfsr_prbs_checker;

  logic        clk, reset, data, valid, clr_err;
  logic        locked, err, locked4, err4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;
  logic [7:0]  lfsr, lfsr4;

  int n_total = 0;
  int n_bad   = 0;

  // Reference: generator sequence b[m] = b[m-8]^b[m-6]^b[m-5]^b[m-4], seed window ..0001.
  bit seq[255];
  int g;

  // Model state: mode 0=search 1=verify 2=locked; window of the last 8 local bits, oldest first.
  int m_mode, m_fill, m_match, m_consec, m_cnt16, m_cnt4;
  bit m_err;
  bit m_hist[$];

  lfsr_prbs_checker dut (
    .clk_i(clk), .reset_i(reset), .data_i(data), .data_valid_i(valid), .clr_err_i(clr_err),
    .locked_o(locked), .err_o(err), .err_count_o(cnt16), .lfsr_o(lfsr)
  );

  lfsr_prbs_checker #(.ERR_CNT_WIDTH(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .data_i(data), .data_valid_i(valid), .clr_err_i(clr_err),
    .locked_o(locked4), .err_o(err4), .err_count_o(cnt4), .lfsr_o(lfsr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_match = 0; m_consec = 0;
    m_cnt16 = 0; m_cnt4 = 0; m_err = 1'b0;
    m_hist = {};
    repeat (8) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input bit x, input bit v, input bit clr);
    bit p, nz;
    m_err = 1'b0;
    if (clr) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end
    if (v) begin
      p  = m_hist[0] ^ m_hist[2] ^ m_hist[3] ^ m_hist[4];
      nz = 1'b0;
      foreach (m_hist[k]) nz |= m_hist[k];
      if (m_mode == 2) m_hist.push_back(p);
      else             m_hist.push_back(x);
      void'(m_hist.pop_front());
      if (m_mode == 0) begin
        m_fill++;
        if (m_fill == 8) begin m_mode = 1; m_match = 0; end
      end else if (m_mode == 1) begin
        if (x == p && nz) m_match++;
        else              m_match = 0;
        if (m_match == 16) begin m_mode = 2; m_consec = 0; end
      end else begin
        if (x != p) begin
          m_err = 1'b1;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15)     m_cnt4++;
          m_consec++;
          if (m_consec == 4) begin m_mode = 0; m_fill = 0; end
        end else begin
          m_consec = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] model_o();
    logic [7:0] o;
    for (int k = 0; k < 8; k++) o[k] = m_hist[7-k];
    return o;
  endfunction

  task automatic drive(input bit b, input bit v, input bit clr, input bit rst);
    data = b; valid = v; clr_err = clr; reset = rst;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_step(b, v, clr);
    check("locked",  32'(locked),  32'(m_mode == 2));
    check("err",     32'(err),     32'(m_err));
    check("cnt16",   32'(cnt16),   32'(m_cnt16));
    check("lfsr",    32'(lfsr),    32'(model_o()));
    check("locked4", 32'(locked4), 32'(m_mode == 2));
    check("err4",    32'(err4),    32'(m_err));
    check("cnt4",    32'(cnt4),    32'(m_cnt4));
    check("lfsr4",   32'(lfsr4),   32'(model_o()));
  endtask

  task automatic send_clean(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      drive(seq[g % 255], 1'b1, 1'b0, 1'b0);
      g++;
    end
  endtask

  task automatic send_err(input bit clr);
    drive(~seq[g % 255], 1'b1, clr, 1'b0);
    g++;
  endtask

  initial begin
    bit ext[263];
    for (int m = 0; m < 8; m++) ext[m] = (m == 7);
    for (int m = 8; m < 263; m++) ext[m] = ext[m-8] ^ ext[m-6] ^ ext[m-5] ^ ext[m-4];
    for (int i = 0; i < 255; i++) seq[i] = ext[i+8];
    g = 0;
    data = 1'b0; valid = 1'b0; clr_err = 1'b0; reset = 1'b1;

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_lfsr", 32'(lfsr), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);

    // 1: clean stream locks exactly after valid bit 24
    send_clean(23, 1'b0);
    check("t1_before_lock", 32'(locked), 32'h0);
    send_clean(1, 1'b0);
    check("t1_lock_at_24", 32'(locked), 32'h1);
    check("t1_cnt", 32'(cnt16), 32'h0);

    // 2: single inverted bit
    send_clean(5, 1'b0);
    send_err(1'b0);
    check("t2_err_pulse", 32'(err), 32'h1);
    check("t2_cnt", 32'(cnt16), 32'h1);
    check("t2_locked", 32'(locked), 32'h1);
    send_clean(20, 1'b0);
    check("t2_cnt_after", 32'(cnt16), 32'h1);

    // 3: clear, then four consecutive errors unlock; relock after 24 bits
    drive(seq[g % 255], 1'b1, 1'b1, 1'b0); g++;
    check("t3_cleared", 32'(cnt16), 32'h0);
    repeat (4) send_err(1'b0);
    check("t3_unlocked", 32'(locked), 32'h0);
    check("t3_cnt", 32'(cnt16), 32'h4);
    send_clean(23, 1'b0);
    check("t3_before_relock", 32'(locked), 32'h0);
    send_clean(1, 1'b0);
    check("t3_relock", 32'(locked), 32'h1);
    check("t3_cnt_kept", 32'(cnt16), 32'h4);

    // 4: constant zeros never lock; a phase-shifted stream then locks within 24 bits
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (100) drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_zero_nolock", 32'(locked), 32'h0);
    check("t4_zero_cnt", 32'(cnt16), 32'h0);
    g = 37;
    send_clean(24, 1'b0);
    check("t4_shift_lock", 32'(locked), 32'h1);

    // 5: narrow counter saturates; clear plus error in one cycle gives 1
    for (int i = 0; i < 20; i++) begin
      send_err(1'b0);
      send_clean(1 + int'($urandom_range(0, 2)), 1'b0);
    end
    check("t5_sat4", 32'(cnt4), 32'hF);
    check("t5_cnt16", 32'(cnt16), 32'd20);
    check("t5_locked", 32'(locked4), 32'h1);
    send_err(1'b1);
    check("t5_clr_count4", 32'(cnt4), 32'h1);
    check("t5_clr_count16", 32'(cnt16), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_clr_idle", 32'(cnt16), 32'h0);

    // 6: valid gaps do not affect lock timing; reset mid-verify restarts from bit 1
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    g = 0;
    send_clean(23, 1'b1);
    check("t6_gap_before", 32'(locked), 32'h0);
    send_clean(1, 1'b1);
    check("t6_gap_lock", 32'(locked), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    g = 0;
    send_clean(12, 1'b1);
    drive(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
    check("t6_rst_lfsr", 32'(lfsr), 32'h0);
    check("t6_rst_locked", 32'(locked), 32'h0);
    check("t6_rst_err", 32'(err), 32'h0);
    g = 0;
    send_clean(23, 1'b1);
    check("t6_relock_before", 32'(locked), 32'h0);
    send_clean(1, 1'b1);
    check("t6_relock", 32'(locked), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
